// File: rtl/mm_sequencer.sv
// mm_sequencer -- address and accumulator control for a streamed matrix product.
//
// One run is started from IDLE by start. It then issues NUM_BEATS beats of
// ROM base addresses in ISSUE. Next it waits PIPE_LAT cycles in DRAIN so the
// last operands can reach the accumulator. Finally it pulses done for one
// cycle in DONE and returns to IDLE.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   start        run request, honoured only in IDLE (abort wins if both are high)
//   abort        cancels a run in ISSUE or DRAIN; the block returns to IDLE with no done
//   romA_addr    A-ROM base address, beat*STRIDE mod 2^13 (zero outside ISSUE)
//   romB_addr    B-ROM base address, beat*STRIDE mod 2^6  (zero outside ISSUE)
//   issue_valid  addresses carry a live beat (high for all of ISSUE)
//   acc_clear    accumulator clears this cycle (the IDLE cycle that launches a run)
//   acc_en       accumulator adds this cycle (issue_valid delayed by PIPE_LAT)
//   busy         high in ISSUE and DRAIN
//   done         one-cycle completion pulse
//   cycle_count  busy cycles of the current or last run, saturating at 16'hFFFF
module mm_sequencer #(
    parameter int NUM_BEATS = 256,
    parameter int STRIDE    = 16,
    parameter int PIPE_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [12:0] romA_addr,
    output logic [5:0]  romB_addr,
    output logic        issue_valid,
    output logic        acc_clear,
    output logic        acc_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] cycle_count
);

    localparam int BEAT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int DRAIN_W = (PIPE_LAT > 1)  ? $clog2(PIPE_LAT)  : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BEAT_W-1:0]   beat;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [PIPE_LAT-1:0] valid_pipe;
    logic                launch;     // IDLE cycle that starts a run
    logic                kill;       // abort taken in ISSUE or DRAIN
    logic [12:0]         beat_offset;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        kill      = 1'b0;
        case (state)
            S_IDLE: begin
                // abort takes priority over a simultaneous start
                if (start && !abort) begin
                    launch    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (beat == LAST_BEAT) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (drain_cnt == LAST_DRAIN) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values from before the edge, whatever the order
    // of the statements.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Beat, drain and busy-cycle counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat        <= '0;
            drain_cnt   <= '0;
            cycle_count <= '0;
        end else begin
            if (launch) begin
                beat <= '0;
            end else if (state == S_ISSUE && !kill) begin
                beat <= beat + BEAT_W'(1);
            end

            // The drain counter restarts at zero every time DRAIN is entered.
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end else begin
                drain_cnt <= '0;
            end

            // The count holds in IDLE and DONE. An aborted cycle is not counted.
            if (launch) begin
                cycle_count <= '0;
            end else if (busy && !kill && cycle_count != 16'hFFFF) begin
                cycle_count <= cycle_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // acc_en delay line: issue_valid delayed by the ROM + operand-register
    // latency. On abort it is flushed so that beats already issued are not
    // accumulated.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
        end else if (kill) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= issue_valid;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Taking the product in 13 bits already gives the A-bank wrap. The
    // B-bank address is the low 6 bits of the same product.
    assign beat_offset = 13'(beat) * 13'(STRIDE);

    assign issue_valid = (state == S_ISSUE);
    assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign romA_addr   = issue_valid ? beat_offset      : 13'd0;
    assign romB_addr   = issue_valid ? beat_offset[5:0] : 6'd0;
    // acc_clear depends directly on start, so it is gated here to stay low
    // while reset is held.
    assign acc_clear   = launch && !reset;
    assign acc_en      = valid_pipe[PIPE_LAT-1];

endmodule

// File: doc/mm_sequencer.md
MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 Parameter NUM_BEATS, default 256: number of 16-element product beats per run.
REQ-002 Parameter STRIDE, default 16: address increment per beat, applied to both ROM address outputs.
REQ-003 Parameter PIPE_LAT, default 2: cycles from address issue to the accumulator input (ROM read plus operand register).
REQ-004 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 Port abort, input, 1 bit: cancel the run in progress.
REQ-008 Port romA_addr, output, 13 bits: base address for the A-ROM bank.
REQ-009 Port romB_addr, output, 6 bits: base address for the B-ROM bank.
REQ-010 Port issue_valid, output, 1 bit: the current addresses are a live beat.
REQ-011 Port acc_clear, output, 1 bit: the accumulator clears to zero this cycle.
REQ-012 Port acc_en, output, 1 bit: the accumulator adds the adder-tree sum this cycle.
REQ-013 Port busy, output, 1 bit: high in ISSUE and DRAIN.
REQ-014 Port done, output, 1 bit: one-cycle completion pulse.
REQ-015 Port cycle_count, output, 16 bits: busy-cycle count of the current or last run.

Function
REQ-016 The block SHALL implement exactly four states: IDLE, ISSUE, DRAIN and DONE.
REQ-017 In IDLE, start=1 and abort=0 SHALL cause these actions:
  - acc_clear=1 for that cycle;
  - cycle_count cleared to 0;
  - beat counter cleared to 0;
  - transition to ISSUE.
REQ-018 In ISSUE, issue_valid SHALL be 1 on every cycle.
REQ-019 In ISSUE, romA_addr SHALL equal beat*STRIDE, truncated to 13 bits.
REQ-020 In ISSUE, romB_addr SHALL equal beat*STRIDE, truncated to 6 bits; with the defaults it wraps 0,16,32,48,0.
REQ-021 The beat counter SHALL increment by 1 per ISSUE cycle.
REQ-022 After the ISSUE cycle with beat=NUM_BEATS-1, the block SHALL enter DRAIN.
REQ-023 The block SHALL remain in DRAIN for exactly PIPE_LAT cycles, then enter DONE.
REQ-024 acc_en SHALL equal issue_valid delayed by PIPE_LAT cycles through a shift register that resets to 0.
REQ-025 The block SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-026 cycle_count SHALL increment by 1 on each cycle busy=1, saturate at 16'hFFFF, and hold its value in DONE and IDLE.
REQ-027 Outside ISSUE, romA_addr, romB_addr and issue_valid SHALL be 0.
REQ-028 start SHALL be ignored in ISSUE, DRAIN and DONE; no queuing.
REQ-029 abort=1 in ISSUE or DRAIN SHALL force these actions on the next edge:
  - return to IDLE;
  - acc_en shift register cleared;
  - no done pulse;
  - cycle_count held.
REQ-030 abort=1 in IDLE or DONE SHALL have no effect, except that abort takes priority over a simultaneous start in IDLE.
REQ-031 NUM_BEATS=1 SHALL give one ISSUE cycle followed by DRAIN with no special case.

Reset
REQ-032 While reset=1, the block SHALL force these values immediately:
  - state=IDLE;
  - beat counter=0;
  - acc_en shift register=0;
  - cycle_count=0;
  - all outputs 0.
REQ-033 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-034 Defaults, start=1 for one cycle at cycle 0 -> the bench SHALL check all of the following:
  - acc_clear=1 at cycle 0;
  - issue_valid=1 for cycles 1..256;
  - acc_en=1 for cycles 3..258;
  - done=1 only at cycle 259;
  - cycle_count=258 at done and held afterwards.
REQ-035 Address sequence during the default run -> the bench SHALL check:
  - romA_addr = 0,16,...,4080, then 0 in DRAIN;
  - romB_addr cycles 0,16,32,48 repeatedly.
REQ-036 start held high for the whole run -> exactly one run and one done pulse, then a new run starts the cycle after DONE (acc_clear=1 in the first IDLE cycle).
REQ-037 abort=1 at beat 100 -> issue_valid=0 and acc_en=0 from the next cycle, no done pulse, cycle_count=100, busy=0.
REQ-038 reset=1 asynchronously at beat 50, released 3 cycles later, then start -> all outputs 0 during reset; the new run completes normally with cycle_count=258.
REQ-039 start=1 and abort=1 together in IDLE -> stays in IDLE, acc_clear=0, previous cycle_count retained.
